// File: rtl/ldm_stm_sequencer_pkg.sv
// Shared definitions for the LDM/STM/PUSH/POP sequencer and data_mem:
// opcode patterns, architectural register numbers and sequencer state encoding.
package ldm_stm_sequencer_pkg;

    localparam logic [4:0] OP_STM_PFX = 5'b11000;
    localparam logic [4:0] OP_LDM_PFX = 5'b11001;
    localparam logic [6:0] OP_PUSH    = 7'b1011010;
    localparam logic [6:0] OP_POP     = 7'b1011110;

    localparam logic [3:0] REG_SP = 4'd13;
    localparam logic [3:0] REG_LR = 4'd14;
    localparam logic [3:0] REG_PC = 4'd15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        XFER   = 2'd1,
        FINISH = 2'd2
    } seq_state_t;

    typedef enum logic [2:0] {
        K_NONE = 3'd0,
        K_STM  = 3'd1,
        K_LDM  = 3'd2,
        K_PUSH = 3'd3,
        K_POP  = 3'd4
    } xfer_kind_t;

    function automatic xfer_kind_t decode_kind(input logic [6:0] op);
        xfer_kind_t k;
        k = K_NONE;
        if (op[6:2] == OP_STM_PFX)      k = K_STM;
        else if (op[6:2] == OP_LDM_PFX) k = K_LDM;
        else if (op == OP_PUSH)         k = K_PUSH;
        else if (op == OP_POP)          k = K_POP;
        return k;
    endfunction

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) c = c + {4'b0, v[i]};
        return c;
    endfunction

endpackage

// File: rtl/ldm_stm_sequencer_reg_list_scan.sv
// Lowest-set-bit finder over a 16-bit register list: index, one-hot clear
// mask and a flag marking the final remaining register.
module reg_list_scan (
    input  logic [15:0] list,
    output logic [3:0]  idx,
    output logic [15:0] clr_mask,
    output logic        last
);

    always_comb begin
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (list[i]) idx = 4'(i);
        end
        clr_mask = list & (~list + 16'd1);
        last     = (list != 16'd0) && ((list & (list - 16'd1)) == 16'd0);
    end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// Expands a Thumb LDMIA/STMIA/PUSH/POP into one data_mem word access per cycle,
// with load writebacks aligned to the 1-cycle read latency and base update.
//
// state  | meaning
// IDLE   | waiting for a valid multiple-register instruction
// XFER   | one register transferred per cycle, lowest index first
// FINISH | done pulse and base-register writeback
module ldm_stm_sequencer
    import ldm_stm_sequencer_pkg::*;
#(
    parameter int ADDR_STEP = 4,
    parameter int SP_IDX    = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [6:0]  opcode,
    input  logic [8:0]  instr_low,
    input  logic [31:0] base_addr,
    input  logic [31:0] store_data_in,
    output logic [3:0]  rf_rd_idx,
    output logic [31:0] mem_addr,
    output logic        mem_write_en,
    output logic [6:0]  mem_opcode,
    output logic [31:0] mem_data_in,
    output logic        ld_wb_en,
    output logic [3:0]  ld_wb_idx,
    output logic        base_wb_en,
    output logic [3:0]  base_wb_idx,
    output logic [31:0] base_wb_value,
    output logic        stall,
    output logic        busy,
    output logic        done
);

    localparam logic [31:0] STEP   = 32'(ADDR_STEP);
    localparam logic [3:0]  SP_REG = 4'(SP_IDX);

    seq_state_t  state_q, state_d;
    xfer_kind_t  kind_q, kind_in;
    logic [15:0] list_q, list_in;
    logic [31:0] addr_q, start_addr_in;
    logic [6:0]  opcode_q;
    logic [3:0]  base_idx_q, base_idx_in, rn_in;
    logic [31:0] base_val_q, base_val_in, span_in;
    logic        base_en_q, base_en_in;
    logic        ld_wb_en_q;
    logic [3:0]  ld_wb_idx_q;
    logic [4:0]  n_in;
    logic        start_ok, is_store_q, xfer_load;
    logic [3:0]  scan_idx;
    logic [15:0] scan_clr;
    logic        scan_last;

    reg_list_scan u_scan (
        .list     (list_q),
        .idx      (scan_idx),
        .clr_mask (scan_clr),
        .last     (scan_last)
    );

    // Decode and precompute everything captured at instruction start.
    always_comb begin
        kind_in = decode_kind(opcode);
        rn_in   = {1'b0, opcode[1:0], instr_low[8]};
        list_in = '0;
        case (kind_in)
            K_STM, K_LDM: list_in = {8'h00, instr_low[7:0]};
            K_PUSH: begin
                list_in = {8'h00, instr_low[7:0]};
                list_in[REG_LR] = instr_low[8];
            end
            K_POP: begin
                list_in = {8'h00, instr_low[7:0]};
                list_in[REG_PC] = instr_low[8];
            end
            default: list_in = '0;
        endcase
        n_in          = popcount16(list_in);
        span_in       = STEP * {27'b0, n_in};
        start_ok      = start && (kind_in != K_NONE);
        base_idx_in   = ((kind_in == K_PUSH) || (kind_in == K_POP)) ? SP_REG : rn_in;
        start_addr_in = (kind_in == K_PUSH) ? base_addr - span_in : base_addr;
        base_val_in   = (kind_in == K_PUSH) ? base_addr - span_in : base_addr + span_in;
        // LDM that reloads its own base keeps the loaded value.
        base_en_in    = (n_in != 5'd0) && !((kind_in == K_LDM) && list_in[rn_in]);
    end

    assign is_store_q = (kind_q == K_STM) || (kind_q == K_PUSH);
    assign xfer_load  = (state_q == XFER) && !is_store_q;

    always_comb begin
        state_d       = state_q;
        rf_rd_idx     = '0;
        mem_addr      = '0;
        mem_write_en  = 1'b0;
        mem_opcode    = '0;
        mem_data_in   = '0;
        base_wb_en    = 1'b0;
        base_wb_idx   = '0;
        base_wb_value = '0;
        stall         = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    stall   = 1'b1;
                    state_d = (n_in == 5'd0) ? FINISH : XFER;
                end
            end
            XFER: begin
                stall      = 1'b1;
                busy       = 1'b1;
                mem_addr   = addr_q;
                mem_opcode = opcode_q;
                if (is_store_q) begin
                    mem_write_en = 1'b1;
                    rf_rd_idx    = scan_idx;
                    mem_data_in  = store_data_in;
                end
                if (scan_last) state_d = FINISH;
            end
            FINISH: begin
                busy          = 1'b1;
                done          = 1'b1;
                base_wb_en    = base_en_q;
                base_wb_idx   = base_idx_q;
                base_wb_value = base_val_q;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ld_wb_en  = ld_wb_en_q;
    assign ld_wb_idx = ld_wb_idx_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            kind_q      <= K_NONE;
            list_q      <= '0;
            addr_q      <= '0;
            opcode_q    <= '0;
            base_idx_q  <= '0;
            base_val_q  <= '0;
            base_en_q   <= 1'b0;
            ld_wb_en_q  <= 1'b0;
            ld_wb_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            ld_wb_en_q  <= xfer_load;
            ld_wb_idx_q <= xfer_load ? scan_idx : 4'd0;
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        kind_q     <= kind_in;
                        list_q     <= list_in;
                        addr_q     <= start_addr_in;
                        opcode_q   <= opcode;
                        base_idx_q <= base_idx_in;
                        base_val_q <= base_val_in;
                        base_en_q  <= base_en_in;
                    end
                end
                XFER: begin
                    list_q <= list_q & ~scan_clr;
                    addr_q <= addr_q + STEP;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed bench for ldm_stm_sequencer: a reference model queues expected
// accesses/writebacks per instruction and each cycle's outputs are checked.
module tb_ldm_stm_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  opcode = '0;
    logic [8:0]  instr_low = '0;
    logic [31:0] base_addr = '0;
    logic [31:0] store_data_in = '0;
    logic [3:0]  rf_rd_idx;
    logic [31:0] mem_addr;
    logic        mem_write_en;
    logic [6:0]  mem_opcode;
    logic [31:0] mem_data_in;
    logic        ld_wb_en;
    logic [3:0]  ld_wb_idx;
    logic        base_wb_en;
    logic [3:0]  base_wb_idx;
    logic [31:0] base_wb_value;
    logic        stall;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;

    logic [31:0] q_addr[$];
    logic [3:0]  q_reg[$];
    logic [3:0]  q_ld[$];

    always #5 clk = ~clk;

    ldm_stm_sequencer #(.ADDR_STEP(4), .SP_IDX(13)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .opcode        (opcode),
        .instr_low     (instr_low),
        .base_addr     (base_addr),
        .store_data_in (store_data_in),
        .rf_rd_idx     (rf_rd_idx),
        .mem_addr      (mem_addr),
        .mem_write_en  (mem_write_en),
        .mem_opcode    (mem_opcode),
        .mem_data_in   (mem_data_in),
        .ld_wb_en      (ld_wb_en),
        .ld_wb_idx     (ld_wb_idx),
        .base_wb_en    (base_wb_en),
        .base_wb_idx   (base_wb_idx),
        .base_wb_value (base_wb_value),
        .stall         (stall),
        .busy          (busy),
        .done          (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string nm);
        check({nm, " busy"},       32'(busy), 32'd0);
        check({nm, " stall"},      32'(stall), 32'd0);
        check({nm, " done"},       32'(done), 32'd0);
        check({nm, " ld_wb_en"},   32'(ld_wb_en), 32'd0);
        check({nm, " base_wb_en"}, 32'(base_wb_en), 32'd0);
        check({nm, " mem_addr"},   mem_addr, 32'd0);
        check({nm, " mem_we"},     32'(mem_write_en), 32'd0);
    endtask

    task automatic run(input logic [6:0] op, input logic [8:0] low, input logic [31:0] base,
                       input bit hold, input string nm);
        logic [15:0] lst;
        bit          is_push, is_pop, is_st, is_ld, exp_en;
        int          n;
        logic [3:0]  rn, exp_idx, r;
        logic [31:0] a, exp_val, sd;
        is_push = (op == 7'b1011010);
        is_pop  = (op == 7'b1011110);
        is_st   = (op[6:2] == 5'b11000) || is_push;
        is_ld   = (op[6:2] == 5'b11001) || is_pop;
        rn      = {1'b0, op[1:0], low[8]};
        lst     = {8'h00, low[7:0]};
        if (is_push) lst[14] = low[8];
        if (is_pop)  lst[15] = low[8];
        n = 0;
        for (int i = 0; i < 16; i++) if (lst[i]) n++;
        a = is_push ? base - 32'(4 * n) : base;
        for (int i = 0; i < 16; i++) begin
            if (lst[i]) begin
                q_reg.push_back(4'(i));
                q_addr.push_back(a);
                if (is_ld) q_ld.push_back(4'(i));
                a = a + 32'd4;
            end
        end
        exp_idx = (is_push || is_pop) ? 4'd13 : rn;
        exp_val = is_push ? base - 32'(4 * n) : base + 32'(4 * n);
        exp_en  = (n != 0) && !(is_ld && !is_pop && lst[rn]);

        start = 1'b1; opcode = op; instr_low = low; base_addr = base; store_data_in = '0;
        @(negedge clk);
        check({nm, " start stall"}, 32'(stall), 32'd1);
        check({nm, " start busy"},  32'(busy), 32'd0);
        check({nm, " start we"},    32'(mem_write_en), 32'd0);
        next_cycle();
        base_addr = 32'hDEAD_BEEF;

        for (int k = 1; k <= n + 1; k++) begin
            start = hold;
            sd = 32'hA500_0000 + 32'(k);
            store_data_in = sd;
            @(negedge clk);
            if (k <= n) begin
                r = q_reg.pop_front();
                a = q_addr.pop_front();
                check({nm, " xfer addr"},   mem_addr, a);
                check({nm, " xfer we"},     32'(mem_write_en), 32'(is_st));
                check({nm, " xfer rd_idx"}, 32'(rf_rd_idx), is_st ? 32'(r) : 32'd0);
                check({nm, " xfer data"},   mem_data_in, is_st ? sd : 32'd0);
                check({nm, " xfer opcode"}, 32'(mem_opcode), 32'(op));
                check({nm, " xfer stall"},  32'(stall), 32'd1);
                check({nm, " xfer done"},   32'(done), 32'd0);
                check({nm, " xfer bwb"},    32'(base_wb_en), 32'd0);
            end else begin
                check({nm, " fin done"},  32'(done), 32'd1);
                check({nm, " fin stall"}, 32'(stall), 32'd0);
                check({nm, " fin busy"},  32'(busy), 32'd1);
                check({nm, " fin we"},    32'(mem_write_en), 32'd0);
                check({nm, " fin addr"},  mem_addr, 32'd0);
                check({nm, " fin bwb_en"}, 32'(base_wb_en), 32'(exp_en));
                if (exp_en) begin
                    check({nm, " fin bwb_idx"}, 32'(base_wb_idx), 32'(exp_idx));
                    check({nm, " fin bwb_val"}, base_wb_value, exp_val);
                end
            end
            if (is_ld && k >= 2) begin
                r = q_ld.pop_front();
                check({nm, " ld_wb_en"},  32'(ld_wb_en), 32'd1);
                check({nm, " ld_wb_idx"}, 32'(ld_wb_idx), 32'(r));
            end else begin
                check({nm, " no ld_wb"}, 32'(ld_wb_en), 32'd0);
            end
            next_cycle();
        end

        start = 1'b0; opcode = '0; instr_low = '0; base_addr = '0; store_data_in = '0;
        @(negedge clk);
        check_quiet({nm, " after"});
        next_cycle();
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) next_cycle();
        @(negedge clk);
        check_quiet("reset");
        next_cycle();
        rst_n = 1'b1;

        run(7'b1100001, 9'b0_0000_1001, 32'h0000_0100, 1'b0, "stm_r2");
        run(7'b1011010, 9'b1_0000_0010, 32'h0000_0200, 1'b0, "push_lr");
        run(7'b1011110, 9'b1_0000_0001, 32'h0000_01F8, 1'b0, "pop_pc");
        run(7'b1100100, 9'b1_0000_0110, 32'h0000_0040, 1'b0, "ldm_rn_in_list");
        run(7'b1100000, 9'b0_0000_0000, 32'h0000_0080, 1'b0, "stm_empty");
        run(7'b1011010, 9'b0_0000_0011, 32'h0000_0004, 1'b0, "push_wrap");
        run(7'b1011110, 9'b1_1111_1111, 32'h0000_1000, 1'b1, "pop_all_hold");

        // Opcodes outside the four patterns must be ignored entirely.
        start = 1'b1; opcode = 7'b0110000; instr_low = 9'h1FF; base_addr = 32'h500;
        @(negedge clk);
        check_quiet("bad_op_a");
        next_cycle();
        opcode = 7'b1011011;
        @(negedge clk);
        check_quiet("bad_op_b");
        next_cycle();
        start = 1'b0;
        @(negedge clk);
        check_quiet("bad_op_after");
        next_cycle();

        // Reset in the second transfer of a 4-register LDM.
        start = 1'b1; opcode = 7'b1100100; instr_low = 9'b0_1111_0000; base_addr = 32'h300;
        next_cycle();
        start = 1'b0; base_addr = '0;
        next_cycle();
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid xfer2 addr", mem_addr, 32'h0000_0304);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check_quiet("rst_mid post1");
        next_cycle();
        @(negedge clk);
        check_quiet("rst_mid post2");
        next_cycle();

        run(7'b1100101, 9'b1_0000_0101, 32'h0000_0300, 1'b0, "ldm_after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
